decoder_nx2n_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready input handshake and an automatic scan mode. Scan mode steps the one-hot output through every code from a start code up to the maximum, holding each for a programmable number of cycles. It replaces the fixed combinational 3-to-8 decoder wherever a registered, flow-controlled select is needed, for example to drive bank/row enables or a self-test sweep.

---
 rtl/decoder_nx2n_seq_pkg.sv | 21 ++
 rtl/decoder_nx2n_seq_if.sv | 26 ++
 rtl/decoder_nx2n_seq_scan_hold_counter.sv | 25 ++
 rtl/decoder_nx2n_seq.sv | 99 +++++++++
 tb/tb_decoder_nx2n_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/decoder_nx2n_seq_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SCAN
  } state_t;

  // Widest select supported by onehot(); callers size-cast to their own N / 2^N.
  localparam int MAX_N = 6;
  localparam int MAX_W = 2 ** MAX_N;

  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] c);
    logic [MAX_W-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_nx2n_seq_if.sv
// Select/handshake bundle between a request source and decoder_nx2n_seq.
interface decoder_nx2n_seq_if #(
  parameter int N = 3
);
  localparam int OUT_W = 2 ** N;

  logic             en;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     I;
  logic [OUT_W-1:0] out;
  logic [N-1:0]     code;
  logic             out_valid;
  logic             scan_done;

  modport master (
    output en, mode, in_valid, I,
    input  in_ready, out, code, out_valid, scan_done
  );

  modport slave (
    input  en, mode, in_valid, I,
    output in_ready, out, code, out_valid, scan_done
  );
endinterface

// File: rtl/decoder_nx2n_seq_scan_hold_counter.sv
// Dwell counter for scan mode: wraps after SCAN_HOLD cycles of run.
module scan_hold_counter #(
  parameter int SCAN_HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic wrap
);
  localparam int            CW   = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_HOLD - 1);

  logic [CW-1:0] cnt;

  assign wrap = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered one-hot decoder with valid/ready intake and a timed upward scan.
module decoder_nx2n_seq
  import decoder_pkg::*;
#(
  parameter int N         = 3,
  parameter int SCAN_HOLD = 10
) (
  input logic               clk,
  input logic               rst,
  decoder_nx2n_seq_if.slave bus
);
  localparam int OUT_W = 2 ** N;

  state_t           state, state_nxt;
  logic             accept, wrap, last_code;
  logic [OUT_W-1:0] out_q, out_d;
  logic [N-1:0]     code_q, code_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  assign bus.in_ready = bus.en && (state == IDLE || state == HOLD);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_code    = (code_q == '1);

  scan_hold_counter #(
    .SCAN_HOLD(SCAN_HOLD)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clear(state != SCAN),
    .run  (state == SCAN),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!bus.en) begin
      state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = bus.mode ? SCAN : HOLD;
    end else if (state == SCAN && wrap && last_code) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    out_d   = out_q;
    code_d  = code_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (!bus.en) begin
      out_d   = '0;
      code_d  = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      out_d   = OUT_W'(onehot(MAX_N'(bus.I)));
      code_d  = bus.I;
      valid_d = 1'b1;
    end else if (state == SCAN && wrap) begin
      // Scan stops at the top code rather than wrapping back to zero.
      if (last_code) begin
        out_d   = '0;
        code_d  = '0;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        out_d  = out_q << 1;
        code_d = code_q + N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.code      = code_q;
  assign bus.out_valid = valid_q;
  assign bus.scan_done = done_q;
endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Bench for decoder_nx2n_seq: two instances (SCAN_HOLD 4 and 1) share stimulus.
module tb_decoder_nx2n_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decoder_nx2n_seq_if #(.N(3)) bus0 ();
  decoder_nx2n_seq_if #(.N(3)) bus1 ();

  decoder_nx2n_seq #(.N(3), .SCAN_HOLD(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  decoder_nx2n_seq #(.N(3), .SCAN_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  logic       t_en = 1'b0, t_valid = 1'b0, t_mode = 1'b0;
  logic [2:0] t_I = '0;

  logic [7:0] a_out[2];
  logic [2:0] a_code[2];
  logic       a_valid[2], a_done[2], a_ready[2];
  assign a_out[0] = bus0.out;       assign a_out[1] = bus1.out;
  assign a_code[0] = bus0.code;     assign a_code[1] = bus1.code;
  assign a_valid[0] = bus0.out_valid; assign a_valid[1] = bus1.out_valid;
  assign a_done[0] = bus0.scan_done;  assign a_done[1] = bus1.scan_done;
  assign a_ready[0] = bus0.in_ready;  assign a_ready[1] = bus1.in_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic v, input logic m, input logic [2:0] i);
    t_en = e; t_valid = v; t_mode = m; t_I = i;
    bus0.en = e; bus0.in_valid = v; bus0.mode = m; bus0.I = i;
    bus1.en = e; bus1.in_valid = v; bus1.mode = m; bus1.I = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a scan is a timeline since its accept; code = start + elapsed/H.
  int hold_c[2] = '{4, 1};
  int m_scan[2] = '{0, 0}, m_valid[2] = '{0, 0}, m_done[2] = '{0, 0};
  int m_code[2] = '{0, 0}, m_start[2] = '{0, 0}, m_el[2] = '{0, 0};

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (rst || !t_en) begin
        m_scan[j] = 0; m_valid[j] = 0; m_done[j] = 0;
        if (rst) m_code[j] = 0;
      end else if (t_valid && m_scan[j] == 0) begin
        m_scan[j] = t_mode ? 1 : 0; m_start[j] = int'(t_I); m_el[j] = 0;
        m_code[j] = int'(t_I); m_valid[j] = 1; m_done[j] = 0;
      end else if (m_scan[j] != 0) begin
        m_el[j]++;
        m_done[j] = 0;
        if (m_el[j] == (8 - m_start[j]) * hold_c[j]) begin
          m_valid[j] = 0; m_done[j] = 1; m_scan[j] = 0;
        end else begin
          m_code[j] = m_start[j] + m_el[j] / hold_c[j];
        end
      end else begin
        m_done[j] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("cyc_out[%0d]", j), a_out[j],
              m_valid[j] != 0 ? (64'd1 << m_code[j]) : 64'd0);
        check($sformatf("cyc_valid[%0d]", j), a_valid[j], m_valid[j] != 0);
        check($sformatf("cyc_done[%0d]", j), a_done[j], m_done[j] != 0);
        check($sformatf("cyc_ready[%0d]", j), a_ready[j], t_en && m_scan[j] == 0);
        if (m_valid[j] != 0) check($sformatf("cyc_code[%0d]", j), a_code[j], m_code[j]);
      end
    end
  end

  initial begin
    int v0, v1, d0, di0, di1, rb0;
    logic [2:0] c1a, c1b;
    logic       d1c;

    drive(1'b1, 1'b0, 1'b0, 3'd0);
    tick(); tick();
    chk_on = 1'b1;
    check("reset_out", bus0.out, 8'h00);
    check("reset_code", bus0.code, 3'd0);
    check("reset_valid", bus0.out_valid, 1'b0);
    check("reset_done", bus0.scan_done, 1'b0);
    check("reset_ready", bus0.in_ready, 1'b1);
    rst = 1'b0;

    // 1: direct sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'(i));
      tick();
      if (i == 0) check("direct_first", bus0.out, 8'b0000_0001);
    end
    check("direct_last", bus0.out, 8'b1000_0000);
    check("direct_last_code", bus0.code, 3'd7);

    // 2: direct hold
    drive(1'b1, 1'b1, 1'b0, 3'd5);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (10) tick();
    check("hold_out", bus0.out, 8'b0010_0000);
    check("hold_code", bus0.code, 3'd5);
    check("hold_ready", bus0.in_ready, 1'b1);

    // 3: full scan from 0
    drive(1'b1, 1'b1, 1'b1, 3'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    v0 = 0; v1 = 0; d0 = 0; di0 = -1; di1 = -1; rb0 = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus0.out_valid) v0++;
      if (bus1.out_valid) v1++;
      if (bus0.scan_done) d0++;
      if (bus0.scan_done && di0 < 0) di0 = k;
      if (bus1.scan_done && di1 < 0) di1 = k;
      if (bus0.out_valid && bus0.in_ready) rb0++;
      tick();
    end
    check("scan_valid_cycles_h4", v0, 32);
    check("scan_done_at_h4", di0, 32);
    check("scan_done_count_h4", d0, 1);
    check("scan_ready_low_h4", rb0, 0);
    check("scan_valid_cycles_h1", v1, 8);
    check("scan_done_at_h1", di1, 8);

    // 4: edge scans
    drive(1'b1, 1'b1, 1'b1, 3'd7);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    check("edge_out", bus0.out, 8'b1000_0000);
    v0 = 0; v1 = 0; di0 = -1; di1 = -1;
    for (int k = 0; k < 8; k++) begin
      if (bus0.out_valid) v0++;
      if (bus1.out_valid) v1++;
      if (bus0.scan_done && di0 < 0) di0 = k;
      if (bus1.scan_done && di1 < 0) di1 = k;
      tick();
    end
    check("edge_valid_h4", v0, 4);
    check("edge_done_at_h4", di0, 4);
    check("edge_valid_h1", v1, 1);
    check("edge_done_at_h1", di1, 1);

    drive(1'b1, 1'b1, 1'b1, 3'd6);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    c1a = bus1.code; tick();
    c1b = bus1.code; tick();
    d1c = bus1.scan_done;
    check("h1_code_a", c1a, 3'd6);
    check("h1_code_b", c1b, 3'd7);
    check("h1_done", d1c, 1'b1);
    repeat (10) tick();

    // 5: abort mid-scan, then en low with in_valid high
    drive(1'b1, 1'b1, 1'b1, 3'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (12) tick();
    check("abort_pre_code", bus0.code, 3'd3);
    drive(1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    check("abort_out", bus0.out, 8'h00);
    check("abort_valid", bus0.out_valid, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 3'd2);
    #1;
    check("en_low_ready", bus0.in_ready, 1'b0);
    d0 = 0; v0 = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus0.scan_done) d0++;
      if (bus0.out_valid) v0++;
      tick();
    end
    check("abort_no_done", d0, 0);
    check("en_low_no_accept", v0, 0);

    // 6: reset mid-scan
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (8) tick();
    check("rst_pre_code", bus0.code, 3'd2);
    rst = 1'b1;
    tick();
    check("rst_out", bus0.out, 8'h00);
    check("rst_valid", bus0.out_valid, 1'b0);
    check("rst_done", bus0.scan_done, 1'b0);
    check("rst_code", bus0.code, 3'd0);
    check("rst_ready", bus0.in_ready, 1'b1);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    check("post_rst_out", bus0.out, 8'b0001_0000);
    check("post_rst_code", bus0.code, 3'd4);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
